// File: rtl/clz_seq_unit.sv
// clz_seq_unit: iterative MIPS CLZ/CLO counter that shifts one bit per cycle.
// Define CLZ_EARLY_ZERO_EN to finish an all-zero loaded value immediately.
module clz_seq_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] operand,
    input  logic             flush,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] result
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d, load;
    logic [CNT_W-1:0] count_q, count_d, result_q, result_d;
    logic accept;
    assign ready  = state_q != RUN;
    assign busy   = state_q == RUN;
    assign done   = state_q == DONE;
    assign result = result_q;
    assign accept = start & ready & ~flush;
    // CLO becomes CLZ of the inverted operand
    assign load   = op ? ~operand : operand;
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        count_d  = count_q;
        result_d = result_q;
        if (flush) begin
            state_d = IDLE;
        end else if (accept) begin
            shreg_d = load;
            count_d = '0;
            state_d = RUN;
`ifdef CLZ_EARLY_ZERO_EN
            if (load == '0) begin
                result_d = CNT_W'(WIDTH);
                state_d  = DONE;
            end
`endif
        end else if (state_q == RUN) begin
            if (shreg_q[WIDTH-1] || count_q == CNT_W'(WIDTH)) begin
                result_d = count_q;
                state_d  = DONE;
            end else begin
                shreg_d = shreg_q << 1;
                count_d = count_q + CNT_W'(1);
            end
        end else if (state_q == DONE) begin
            state_d = IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end
endmodule

// File: tb/tb_clz_seq_unit.sv
// tb_clz_seq_unit: randomized and directed checks of clz_seq_unit against a bit-scan model.
// Latency expectations follow CLZ_EARLY_ZERO_EN when it is defined.
module tb_clz_seq_unit;
    localparam int W = 32;
    localparam int C = 6;
    logic clk = 0, rst = 1, start = 0, op = 0, flush = 0;
    logic [W-1:0] operand = '0;
    logic ready, busy, done;
    logic [C-1:0] result;
    int checks = 0, errors = 0;

    clz_seq_unit #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .operand(operand),
        .flush(flush), .ready(ready), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic int lead(input logic o, input logic [W-1:0] v);
        int k = 0;
        for (int i = W - 1; i >= 0; i--) begin
            if (v[i] != o) break;
            k++;
        end
        return k;
    endfunction

    function automatic int exp_lat(input int k);
`ifdef CLZ_EARLY_ZERO_EN
        if (k == W) return 1;
`endif
        return k + 2;
    endfunction

    // Drives a start in cycle 0; returns at the sampling point of cycle 1.
    task automatic issue(input logic o, input logic [W-1:0] v);
        start = 1; op = o; operand = v;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = from;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        checks += 4;
        if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
        if (result !== '0) begin errors++; $display("FAIL reset_result got=%0d exp=0", result); end
    endtask

    task automatic test_directed;
        logic [W-1:0] vals [5] = '{32'h8000_0000, 32'h0001_0000, 32'hFFF0_0000, 32'hFFFF_FFFF, 32'h0};
        logic ops [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        int lat, k;
        for (int i = 0; i < 5; i++) begin
            k = lead(ops[i], vals[i]);
            issue(ops[i], vals[i]);
            if (exp_lat(k) > 1) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL dir%0d_busy got=%b exp=1", i, busy); end
            end
            wait_done(1, lat);
            checks += 2;
            if (lat != exp_lat(k)) begin errors++; $display("FAIL dir%0d_latency got=%0d exp=%0d", i, lat, exp_lat(k)); end
            if (result !== C'(k)) begin errors++; $display("FAIL dir%0d_result got=%0d exp=%0d", i, result, k); end
            @(negedge clk);
        end
    endtask

    task automatic test_random;
        logic [W-1:0] x, v;
        logic o;
        int lat, k;
        for (int i = 0; i < 40; i++) begin
            o = 1'($urandom_range(0, 1));
            x = $urandom >> $urandom_range(0, 32);
            v = o ? ~x : x;
            k = lead(o, v);
            issue(o, v);
            wait_done(1, lat);
            checks += 2;
            if (lat != exp_lat(k)) begin errors++; $display("FAIL rnd%0d_latency got=%0d exp=%0d", i, lat, exp_lat(k)); end
            if (result !== C'(k)) begin errors++; $display("FAIL rnd%0d_result v=%h op=%b got=%0d exp=%0d", i, v, o, result, k); end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        issue(1'b0, 32'h0001_0000);
        wait_done(1, lat);
        checks += 3;
        if (done !== 1'b1) begin errors++; $display("FAIL b2b_first_done got=%b exp=1", done); end
        if (result !== C'(15)) begin errors++; $display("FAIL b2b_first_result got=%0d exp=15", result); end
        if (ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_done got=%b exp=1", ready); end
        issue(1'b0, 32'h4000_0000);
        issue(1'b0, 32'h0);
        wait_done(2, lat);
        checks += 2;
        if (lat != 3) begin errors++; $display("FAIL b2b_second_latency got=%0d exp=3", lat); end
        if (result !== C'(1)) begin errors++; $display("FAIL b2b_second_result got=%0d exp=1", result); end
        @(negedge clk);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_ignored_start_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL b2b_done_width got=%b exp=0", done); end
    endtask

    task automatic test_flush;
        int lat, seen = 0;
        issue(1'b0, 32'h0001_0000);
        wait_done(1, lat);
        @(negedge clk);
        issue(1'b0, 32'h0000_0001);
        repeat (4) @(negedge clk);
        flush = 1;
        @(negedge clk);
        flush = 0;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy got=%b exp=0", busy); end
        if (ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", ready); end
        if (done !== 1'b0) begin errors++; $display("FAIL flush_done got=%b exp=0", done); end
        if (result !== C'(15)) begin errors++; $display("FAIL flush_result got=%0d exp=15", result); end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) seen++;
        end
        checks++;
        if (seen != 0) begin errors++; $display("FAIL flush_no_done got=%0d exp=0", seen); end
        flush = 1;
        issue(1'b0, 32'h8000_0000);
        flush = 0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_flush_busy got=%b exp=0", busy); end
        @(negedge clk);
        checks += 2;
        if (done !== 1'b0) begin errors++; $display("FAIL start_flush_done got=%b exp=0", done); end
        if (result !== C'(15)) begin errors++; $display("FAIL start_flush_result got=%0d exp=15", result); end
    endtask

    task automatic test_reset_mid_op;
        issue(1'b0, 32'h0000_0100);
        repeat (3) @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
        if (done !== 1'b0) begin errors++; $display("FAIL rst_mid_done got=%b exp=0", done); end
        if (result !== '0) begin errors++; $display("FAIL rst_mid_result got=%0d exp=0", result); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_directed;
        test_random;
        test_back_to_back;
        test_flush;
        test_reset_mid_op;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
